// File: rtl/led_status_driver.sv
// Board LED driver: heartbeat, link-up and stretched activity lamps with PWM dimming,
// overridden by a repeating blink pattern while an error code is latched.
module led_status_driver #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned HB_HALF_MS = 500,
  parameter int unsigned STRETCH_MS = 50,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned GAP_MS     = 1000,
  parameter int unsigned PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                link_up,
  input  logic [5:0]          act_in,
  input  logic                err_valid,
  input  logic [3:0]          err_code,
  input  logic                err_clear,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                err_active,
  output logic [7:0]          led
);

  localparam int unsigned CH      = 6;
  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HB_W    = $clog2(HB_HALF_MS + 1);
  localparam int unsigned STR_W   = $clog2(STRETCH_MS + 1);
  localparam int unsigned TMR_MAX = (BLINK_MS > GAP_MS) ? BLINK_MS : GAP_MS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {NORMAL, ERR_ON, ERR_OFF, ERR_GAP} state_t;

  logic [PRE_W-1:0]    presc;
  logic                ms_tick;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb;
  logic [STR_W-1:0]    str_cnt [CH];
  logic [CH-1:0]       lamp;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                en;
  logic [7:0]          raw;

  state_t              state, state_d;
  logic [TMR_W-1:0]    timer, timer_d;
  logic [3:0]          blink_n, blink_d;
  logic [3:0]          code, code_d;

  // 1 ms time base; ms_tick is registered so it does not fire straight out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      ms_tick <= 1'b0;
    end else begin
      ms_tick <= (presc == PRE_W'(TICK_DIV - 1));
      presc   <= (presc == PRE_W'(TICK_DIV - 1)) ? '0 : presc + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (ms_tick) begin
      if (hb_cnt == HB_W'(HB_HALF_MS - 1)) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end
    end
  end

  // Activity stretch: a pulse (re)loads the hold, ms ticks drain it
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (act_in[i])
          str_cnt[i] <= STR_W'(STRETCH_MS);
        else if (ms_tick && (str_cnt[i] != '0))
          str_cnt[i] <= str_cnt[i] - STR_W'(1);
      end
    end
  end

  always_comb begin
    lamp = '0;
    for (int i = 0; i < CH; i++) lamp[i] = (str_cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= NORMAL;
      timer   <= '0;
      blink_n <= '0;
      code    <= '0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      blink_n <= blink_d;
      code    <= code_d;
    end
  end

  // Blink sequencing, then clear / re-latch overrides
  always_comb begin
    state_d = state;
    timer_d = timer;
    blink_d = blink_n;
    code_d  = code;
    raw     = 8'h00;
    case (state)
      NORMAL: raw = {lamp, link_up, hb};
      ERR_ON: begin
        raw = 8'hFF;
        if (ms_tick) begin
          if (timer == TMR_W'(BLINK_MS - 1)) begin
            state_d = ERR_OFF;
            timer_d = '0;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end
      ERR_OFF: begin
        if (ms_tick) begin
          if (timer == TMR_W'(BLINK_MS - 1)) begin
            timer_d = '0;
            if (blink_n == code) begin
              state_d = ERR_GAP;
            end else begin
              state_d = ERR_ON;
              blink_d = blink_n + 4'd1;
            end
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end
      ERR_GAP: begin
        if (ms_tick) begin
          if (timer == TMR_W'(GAP_MS - 1)) begin
            state_d = ERR_ON;
            timer_d = '0;
            blink_d = 4'd1;
          end else begin
            timer_d = timer + TMR_W'(1);
          end
        end
      end
      default: state_d = NORMAL;
    endcase
    if (err_clear) begin
      state_d = NORMAL;
      timer_d = '0;
      blink_d = '0;
      code_d  = '0;
    end else if (err_valid && (err_code != 4'd0)) begin
      state_d = ERR_ON;
      timer_d = '0;
      blink_d = 4'd1;
      code_d  = err_code;
    end
  end

  assign en = (brightness == '1) || (pwm_cnt < brightness);

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt    <= '0;
      led        <= '0;
      err_active <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + PWM_BITS'(1);
      led        <= raw & {8{en}};
      err_active <= (state_d != NORMAL);
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver using scaled-down timing parameters.
module tb_led_status_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       link_up;
  logic [5:0] act_in;
  logic       err_valid;
  logic [3:0] err_code;
  logic       err_clear;
  logic [3:0] brightness;
  logic       err_active;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  led_status_driver #(
    .TICK_DIV(10), .HB_HALF_MS(4), .STRETCH_MS(3),
    .BLINK_MS(2), .GAP_MS(5), .PWM_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .link_up(link_up), .act_in(act_in),
    .err_valid(err_valid), .err_code(err_code), .err_clear(err_clear),
    .brightness(brightness), .err_active(err_active), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Count consecutive negedge samples where (led & mask) == v
  task automatic run_len(input logic [7:0] mask, input logic [7:0] v, output int n);
    n = 0;
    while (((led & mask) == v) && (n < 300)) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_led(input string tag, input logic [7:0] mask, input logic [7:0] v, input int max);
    int n = 0;
    while (((led & mask) != v) && (n < max)) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(led & mask), 32'(v));
  endtask

  task automatic strobe_err(input logic [3:0] c);
    err_valid = 1'b1;
    err_code  = c;
    @(negedge clk);
    err_valid = 1'b0;
    err_code  = 4'd0;
  endtask

  task automatic pulse_act(input logic [5:0] a);
    act_in = a;
    @(negedge clk);
    act_in = 6'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int cnt2;
    reset = 1'b1; link_up = 1'b1; act_in = 6'h3F; err_valid = 1'b1;
    err_code = 4'd3; err_clear = 1'b0; brightness = 4'hF;

    // 1: outputs held low during reset, then heartbeat and link-up
    repeat (4) begin
      @(negedge clk);
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_err", 32'(err_active), 32'h0);
    end
    link_up = 1'b0; act_in = 6'd0; err_valid = 1'b0; err_code = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_led", 32'(led), 32'h0);
    wait_led("hb_rise", 8'h01, 8'h01, 100);
    run_len(8'h01, 8'h01, n); chk("hb_high_len", 32'(n), 32'd40);
    run_len(8'h01, 8'h00, n); chk("hb_low_len", 32'(n), 32'd40);
    chk("link_pre", 32'(led[1]), 32'h0);
    link_up = 1'b1;
    @(negedge clk);
    chk("link_led1", 32'(led[1]), 32'h1);

    // 2: activity stretch, single pulse and re-armed pulse
    pulse_act(6'b000001);
    chk("act_n1", 32'(led[2]), 32'h0);
    @(negedge clk);
    chk("act_n2", 32'(led[2]), 32'h1);
    run_len(8'h04, 8'h04, n);
    chk("act_hold", 32'((n >= 21) && (n <= 31)), 32'h1);
    chk("act_other", 32'(led[7:3]), 32'h0);
    repeat (5) @(negedge clk);
    pulse_act(6'b000001);
    repeat (19) @(negedge clk);
    chk("act_mid", 32'(led[2]), 32'h1);
    pulse_act(6'b000001);
    run_len(8'h04, 8'h04, n);
    chk("act_rearm", 32'((n >= 22) && (n <= 31)), 32'h1);

    // 5: PWM duty
    brightness = 4'h4;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (16) begin cnt += int'(led[1]); @(negedge clk); end
    chk("pwm_4", 32'(cnt), 32'd4);
    brightness = 4'h0;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (16) begin cnt += int'(led != 8'h00); @(negedge clk); end
    chk("pwm_0", 32'(cnt), 32'd0);
    brightness = 4'hF;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (16) begin cnt += int'(led[1]); @(negedge clk); end
    chk("pwm_F", 32'(cnt), 32'd16);

    // 3: error code 3 blink pattern
    link_up = 1'b0;
    strobe_err(4'd3);
    chk("err_act_n1", 32'(err_active), 32'h1);
    @(negedge clk);
    chk("err_led_n2", 32'(led), 32'hFF);
    run_len(8'hFF, 8'hFF, n);
    run_len(8'hFF, 8'h00, n); chk("c3_off1", 32'(n), 32'd20);
    run_len(8'hFF, 8'hFF, n); chk("c3_on2", 32'(n), 32'd20);
    run_len(8'hFF, 8'h00, n); chk("c3_off2", 32'(n), 32'd20);
    run_len(8'hFF, 8'hFF, n); chk("c3_on3", 32'(n), 32'd20);
    run_len(8'hFF, 8'h00, n); chk("c3_gap", 32'(n), 32'd70);
    run_len(8'hFF, 8'hFF, n); chk("c3_rep_on", 32'(n), 32'd20);
    chk("c3_err_act", 32'(err_active), 32'h1);

    // 4: re-latch mid blink, ignored zero code, clear beats valid
    strobe_err(4'd2);
    @(negedge clk);
    chk("relatch_on", 32'(led), 32'hFF);
    run_len(8'hFF, 8'hFF, n);
    run_len(8'hFF, 8'h00, n); chk("c2_off1", 32'(n), 32'd20);
    run_len(8'hFF, 8'hFF, n); chk("c2_on2", 32'(n), 32'd20);
    run_len(8'hFF, 8'h00, n); chk("c2_gap", 32'(n), 32'd70);
    run_len(8'hFF, 8'hFF, n); chk("c2_rep_on", 32'(n), 32'd20);
    strobe_err(4'd0);
    @(negedge clk);
    chk("code0_led", 32'(led), 32'h00);
    chk("code0_act", 32'(err_active), 32'h1);
    err_clear = 1'b1; err_valid = 1'b1; err_code = 4'd5;
    @(negedge clk);
    err_clear = 1'b0; err_valid = 1'b0; err_code = 4'd0;
    chk("clr_act", 32'(err_active), 32'h0);
    @(negedge clk);
    chk("clr_led", 32'(led[7:1]), 32'h0);
    cnt = 0;
    repeat (30) begin cnt += int'(err_active) + int'(led == 8'hFF); @(negedge clk); end
    chk("clr_stays", 32'(cnt), 32'd0);

    // 6: reset during ERR_OFF
    strobe_err(4'd1);
    wait_led("r6_on", 8'hFF, 8'hFF, 40);
    wait_led("r6_off", 8'hFF, 8'h00, 40);
    reset = 1'b1;
    @(negedge clk);
    chk("r6_led", 32'(led), 32'h0);
    chk("r6_act", 32'(err_active), 32'h0);
    reset = 1'b0;
    link_up = 1'b1;
    cnt = 0; cnt2 = 0;
    repeat (120) begin
      @(negedge clk);
      cnt  += int'(led == 8'hFF);
      cnt2 += int'(err_active);
    end
    chk("r6_no_blink", 32'(cnt), 32'd0);
    chk("r6_no_err", 32'(cnt2), 32'd0);
    chk("r6_link", 32'(led[1]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
